// File: rtl/tdm_pkg.sv
// rtl/tdm_pkg.sv - shared constants, state encoding and slot helper for the 8-slot TDM receive path
package tdm_pkg;

    localparam int NUM_SLOTS  = 8;
    localparam int SLOT_IDX_W = 3;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    function automatic logic is_last_slot(input logic [SLOT_IDX_W-1:0] idx);
        return idx == SLOT_IDX_W'(NUM_SLOTS - 1);
    endfunction

endpackage

// File: rtl/decoder_3x8.sv
// rtl/decoder_3x8.sv - slot index plus enable to one-hot shadow write-enable
module decoder_3x8
    import tdm_pkg::*;
(
    input  logic [SLOT_IDX_W-1:0] idx,
    input  logic                  en,
    output logic [NUM_SLOTS-1:0]  onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/tdm_demux_1x8.sv
// rtl/tdm_demux_1x8.sv - 1:8 TDM receive demux publishing whole frames; TDM_DEMUX_AUTOSYNC_EN enables frame_start-free continuation
module tdm_demux_1x8
    import tdm_pkg::*;
#(
    parameter int W = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [W-1:0]          din,
    input  logic                  din_valid,
    input  logic                  frame_start,
    output logic [W-1:0]          y0,
    output logic [W-1:0]          y1,
    output logic [W-1:0]          y2,
    output logic [W-1:0]          y3,
    output logic [W-1:0]          y4,
    output logic [W-1:0]          y5,
    output logic [W-1:0]          y6,
    output logic [W-1:0]          y7,
    output logic                  frame_valid,
    output logic [SLOT_IDX_W-1:0] slot,
    output logic                  sync_err
);

    state_t                state_q;
    state_t                state_d;
    logic [SLOT_IDX_W-1:0] slot_q;
    logic [SLOT_IDX_W-1:0] slot_d;
    logic [SLOT_IDX_W-1:0] wr_idx;
    logic                  take;
    logic                  err_d;
    logic                  resync_ok;
    logic                  frame_done;
    logic [NUM_SLOTS-1:0]  wr_en;

    logic [W-1:0] shadow [0:NUM_SLOTS-2];
    logic [W-1:0] y_q    [0:NUM_SLOTS-1];

`ifdef TDM_DEMUX_AUTOSYNC_EN
    // Set by the first completed frame; lets later frames start without frame_start.
    logic locked_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            locked_q <= 1'b0;
        end else if (frame_done) begin
            locked_q <= 1'b1;
        end
    end

    assign resync_ok = locked_q;
`else
    assign resync_ok = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            slot_q  <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
        end
    end

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        wr_idx  = slot_q;
        take    = 1'b0;
        err_d   = 1'b0;

        if (din_valid) begin
            case (state_q)
                IDLE: begin
                    if (frame_start || resync_ok) begin
                        take   = 1'b1;
                        wr_idx = '0;
                    end
                end
                COLLECT: begin
                    take = 1'b1;
                    // Slot is never 0 while collecting, so any frame_start here is a resync.
                    if (frame_start) begin
                        wr_idx = '0;
                        err_d  = 1'b1;
                    end
                end
                default: begin
                    take = 1'b0;
                end
            endcase
        end

        if (take) begin
            if (is_last_slot(wr_idx)) begin
                slot_d  = '0;
                state_d = IDLE;
            end else begin
                slot_d  = wr_idx + SLOT_IDX_W'(1);
                state_d = COLLECT;
            end
        end
    end

    decoder_3x8 u_decoder (
        .idx    (wr_idx),
        .en     (take),
        .onehot (wr_en)
    );

    assign frame_done = wr_en[NUM_SLOTS-1];

    // The last beat bypasses the shadow bank so the frame appears one cycle after it.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_SLOTS - 1; k++) begin
                shadow[k] <= '0;
            end
            for (int k = 0; k < NUM_SLOTS; k++) begin
                y_q[k] <= '0;
            end
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            frame_valid <= frame_done;
            sync_err    <= err_d;
            for (int k = 0; k < NUM_SLOTS - 1; k++) begin
                if (wr_en[k]) begin
                    shadow[k] <= din;
                end
            end
            if (frame_done) begin
                for (int k = 0; k < NUM_SLOTS - 1; k++) begin
                    y_q[k] <= shadow[k];
                end
                y_q[NUM_SLOTS-1] <= din;
            end
        end
    end

    assign slot = slot_q;
    assign y0   = y_q[0];
    assign y1   = y_q[1];
    assign y2   = y_q[2];
    assign y3   = y_q[3];
    assign y4   = y_q[4];
    assign y5   = y_q[5];
    assign y6   = y_q[6];
    assign y7   = y_q[7];

endmodule

// File: tb/tb_tdm_demux_1x8.sv
// tb/tb_tdm_demux_1x8.sv - table vectors, corner sequences and randomized stimulus against a frame-level model
module tb_tdm_demux_1x8;

    localparam int W = 4;
`ifdef TDM_DEMUX_AUTOSYNC_EN
    localparam bit AUTOSYNC = 1'b1;
`else
    localparam bit AUTOSYNC = 1'b0;
`endif
    localparam logic [31:0] Y1 = 32'h0100_1101;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] din;
    logic         din_valid;
    logic         frame_start;
    logic [W-1:0] y0, y1, y2, y3, y4, y5, y6, y7;
    logic         frame_valid;
    logic [2:0]   slot;
    logic         sync_err;

    always #5 clk = ~clk;

    tdm_demux_1x8 #(.W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
        .frame_start (frame_start),
        .y0          (y0),
        .y1          (y1),
        .y2          (y2),
        .y3          (y3),
        .y4          (y4),
        .y5          (y5),
        .y6          (y6),
        .y7          (y7),
        .frame_valid (frame_valid),
        .slot        (slot),
        .sync_err    (sync_err)
    );

    int total = 0;
    int bad   = 0;
    int fv_cnt = 0;
    int cyc = 0;
    int fv_cycles[$];

    // Frame-level model: beats accumulate in a queue; eight beats make a frame.
    logic [W-1:0] m_buf[$];
    logic [W-1:0] m_y[8];
    bit           m_fv, m_se, m_locked;

    function automatic void model_step();
        m_fv = 1'b0;
        m_se = 1'b0;
        if (rst) begin
            m_buf.delete();
            for (int k = 0; k < 8; k++) m_y[k] = '0;
            m_locked = 1'b0;
        end else if (din_valid) begin
            if (frame_start) begin
                if (m_buf.size() > 0) m_se = 1'b1;
                m_buf.delete();
                m_buf.push_back(din);
            end else if (m_buf.size() > 0 || (AUTOSYNC && m_locked)) begin
                m_buf.push_back(din);
            end
            if (m_buf.size() == 8) begin
                for (int k = 0; k < 8; k++) m_y[k] = m_buf[k];
                m_buf.delete();
                m_fv = 1'b1;
                m_locked = 1'b1;
            end
        end
    endfunction

    function automatic logic [31:0] dut_y();
        return {y7, y6, y5, y4, y3, y2, y1, y0};
    endfunction

    function automatic logic [31:0] model_y();
        logic [31:0] v;
        for (int k = 0; k < 8; k++) v[k*4 +: 4] = m_y[k];
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic s, input logic [W-1:0] d);
        rst = r;
        din_valid = v;
        frame_start = s;
        din = d;
        @(posedge clk);
        model_step();
        cyc++;
        #1;
        if (frame_valid === 1'b1) begin
            fv_cnt++;
            fv_cycles.push_back(cyc);
        end
    endtask

    task automatic tick(input logic r, input logic v, input logic s, input logic [W-1:0] d);
        drive(r, v, s, d);
        check("y", dut_y(), model_y());
        check("frame_valid", 32'(frame_valid), 32'(m_fv));
        check("sync_err", 32'(sync_err), 32'(m_se));
        check("slot", 32'(slot), 32'(m_buf.size()));
    endtask

    typedef struct {
        logic         r, v, s;
        logic [W-1:0] d;
        logic         fv, se;
        logic [2:0]   sl;
        logic [31:0]  y;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic v, input logic s, input logic [W-1:0] d,
                                input logic fv, input logic se, input logic [2:0] sl, input logic [31:0] y);
        vec_t t;
        t.r = r; t.v = v; t.s = s; t.d = d;
        t.fv = fv; t.se = se; t.sl = sl; t.y = y;
        return t;
    endfunction

    initial begin
        vec_t        tbl[$];
        logic [7:0]  pat;
        logic [W-1:0] val;
        int          exp_pulses;

        rst = 1'b1; din_valid = 1'b0; frame_start = 1'b0; din = '0;

        pat = 8'b0100_1101;
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 8; k++)
            tbl.push_back(mk(0, 1, k == 0, {3'b000, pat[k]}, k == 7, 0,
                             (k == 7) ? 3'd0 : 3'(k + 1), (k == 7) ? Y1 : 32'h0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, Y1));
        for (int k = 0; k < 5; k++)
            tbl.push_back(mk(0, 1, k == 0, 4'h1, 0, 0, 3'(k + 1), Y1));
        tbl.push_back(mk(0, 1, 1, 4'h0, 0, 1, 3'd1, Y1));
        for (int k = 1; k < 8; k++)
            tbl.push_back(mk(0, 1, 0, 4'h0, k == 7, 0,
                             (k == 7) ? 3'd0 : 3'(k + 1), (k == 7) ? 32'h0 : Y1));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].r, tbl[i].v, tbl[i].s, tbl[i].d);
            check("tbl_y", dut_y(), tbl[i].y);
            check("tbl_frame_valid", 32'(frame_valid), 32'(tbl[i].fv));
            check("tbl_sync_err", 32'(sync_err), 32'(tbl[i].se));
            check("tbl_slot", 32'(slot), 32'(tbl[i].sl));
        end

        // Gaps inside a frame.
        tick(1, 0, 0, 0);
        fv_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            tick(0, 1, k == 0, {3'b000, pat[k]});
            if (k == 3) for (int g = 0; g < 3; g++) tick(0, 0, 0, 4'hA);
        end
        tick(0, 0, 0, 0);
        check("gap_pulses", 32'(fv_cnt), 32'd1);
        check("gap_y", dut_y(), Y1);

        // Back-to-back frames with no bubble.
        fv_cnt = 0;
        fv_cycles.delete();
        for (int i = 0; i < 16; i++) begin
            tick(0, 1, (i % 8) == 0, 4'(i));
            if (i == 7) check("b2b_first_y", dut_y(), 32'h7654_3210);
        end
        check("b2b_pulses", 32'(fv_cnt), 32'd2);
        if (fv_cycles.size() == 2) check("b2b_spacing", 32'(fv_cycles[1] - fv_cycles[0]), 32'd8);
        else check("b2b_spacing_count", 32'(fv_cycles.size()), 32'd2);
        check("b2b_second_y", dut_y(), 32'hFEDC_BA98);

        // Reset in the middle of a frame.
        fv_cnt = 0;
        for (int i = 0; i < 5; i++) tick(0, 1, i == 0, 4'hC);
        tick(1, 1, 0, 4'hC);
        check("midrst_y", dut_y(), 32'h0);
        check("midrst_slot", 32'(slot), 32'd0);
        check("midrst_pulses", 32'(fv_cnt), 32'd0);
        for (int i = 0; i < 8; i++) tick(0, 1, i == 0, 4'(i + 3));
        check("midrst_next_y", dut_y(), 32'hA987_6543);

        // Continuous stream with a single frame_start.
        tick(1, 0, 0, 0);
        fv_cnt = 0;
        for (int i = 0; i < 16; i++) tick(0, 1, i == 0, 4'($urandom_range(0, 15)));
        exp_pulses = AUTOSYNC ? 2 : 1;
        check("autosync_pulses", 32'(fv_cnt), 32'(exp_pulses));

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            val = 4'($urandom_range(0, 15));
            tick(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 9) == 0), val);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tdm_demux_1x8.md
Name: tdm_demux_1x8

Overview:
- Receive end of the 8-slot time-division link whose transmit side is the 8:1 select tree driven by a 3-bit slot counter.
- Takes one W-bit beat per valid cycle and steers it into slot register 0..7 by an internal slot counter.
- Publishes all 8 slots together as one frame with a one-cycle frame_valid pulse.
- Sits after the serial link and in front of per-channel consumers.

Parameters:
- W, 1, width of each slot and of din.
- NUM_SLOTS, 8, slots per frame; fixed at 8, slot index is 3 bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- din  input  W  slot data beat.
- din_valid  input  1  din is valid this cycle.
- frame_start  input  1  qualifies the current valid beat as slot 0; ignored when din_valid=0.
- y0..y7  output  W each  registered frame outputs, slot k on yk.
- frame_valid  output  1  one-cycle pulse when y0..y7 hold a new complete frame.
- slot  output  3  index the next valid beat will be written to.
- sync_err  output  1  one-cycle pulse when frame_start arrives mid-frame.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, slot=0, shadow regs=0, y0..y7=0, frame_valid=0, sync_err=0. Reset overrides everything, including a mid-frame reset; the partial frame is discarded.
- IDLE state:
  - A beat with din_valid=1 and frame_start=1 writes shadow[0], sets slot=1 and moves to COLLECT.
  - A beat with din_valid=1 and frame_start=0 is dropped; slot stays 0.
- COLLECT state, beat with din_valid=1 and frame_start=0: writes shadow[slot], then slot+1.
- COLLECT state, beat with din_valid=1 and frame_start=1 while slot!=0:
  - sync_err pulses the next cycle.
  - The partial frame is discarded.
  - The beat is written as shadow[0], slot=1, state stays COLLECT.
- din_valid=0 in any state: slot, shadow regs and outputs hold; no timeout.
- Frame completion (slot-7 beat):
  - On the clk edge that writes slot 7, y0..y6 load from shadow[0..6] and y7 loads din directly. The slot-7 data is not delayed an extra cycle.
  - frame_valid=1 for exactly that following cycle.
  - slot wraps to 0 and state returns to IDLE.
- Back-to-back frames: a frame_start beat on the cycle right after slot 7 is accepted with no bubble. Throughput is 1 beat/cycle.
- y0..y7 change only on frame completion or reset. A partial frame never reaches them.
- Latency: last beat to frame_valid and new y is 1 cycle.
- sync_err and frame_valid are mutually exclusive. A frame_start on the slot-7 position is a sync error, not a completion.

Optional Feature:
- Macro: TDM_DEMUX_AUTOSYNC_EN.
- Defined: after a completed frame, the next valid beat is taken as slot 0 even when frame_start=0, so a continuous stream needs frame_start only on its first frame. frame_start=1 keeps the same meaning and error checking.
- Undefined: behaviour exactly as above; every frame needs frame_start.

Decomposition:
- Shared package tdm_pkg holds:
  - NUM_SLOTS=8.
  - SLOT_IDX_W=3.
  - state encoding IDLE=1'b0, COLLECT=1'b1.
- One sub-module, decoder_3x8: combinational slot index plus enable to an 8-bit one-hot shadow write-enable. It is the counterpart of the select tree.
- Counter, FSM and registers stay in tdm_demux_1x8.

Test Plan:
- Reset then one frame: W=1, frame_start on beat 0, din_valid=1 for 8 cycles with bits 1,0,1,1,0,0,1,0 → the cycle after beat 7: frame_valid=1, y0..y7=1,0,1,1,0,0,1,0, slot=0.
- Gaps: same frame with din_valid=0 for 3 cycles after beat 3 → identical y; frame_valid is still a single pulse; y is unchanged during the gap.
- Mid-frame resync: 5 beats of 1, then frame_start beat 0 followed by 7 beats of 0 → sync_err pulse at the 6th beat; then frame_valid with all y=0; no earlier frame_valid.
- Back-to-back: two frames W=4, values 0..7 then 8..15, with no idle cycle → frame_valid pulses 8 cycles apart; y holds 0..7, then 8..15.
- Mid-frame reset: rst=1 after beat 4 → next cycle all y=0, slot=0, no frame_valid; the subsequent complete frame is received correctly.
- Autosync: with TDM_DEMUX_AUTOSYNC_EN, 16 beats with frame_start only on beat 0 → two frame_valid pulses. Without the macro → one pulse and beats 8..15 are dropped.
